lsq: RTL

Parametrised load/store queue that replaces the fixed 16-entry buffer between the decoder/ROB and the memory controller. It adds several capabilities:
- configurable depth and wake-up channel count;
- same-cycle dispatch bypass from the broadcast buses;
- non-speculative handling of memory-mapped I/O loads;
- rollback that keeps committed stores and drains an in-flight speculative load.

Memory is accessed strictly in program order from the queue head, one request at a time.

---
 rtl/lsq_pkg.sv | 22 ++
 rtl/load_ext.sv | 23 ++
 rtl/lsq.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsq_pkg.sv
// Shared constants for the load/store queue.
// funct3 codes, datapath widths, I/O window base and FSM encoding.
package lsq_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] IO_BASE_DEF = 32'h0003_0000;

    localparam logic [2:0] FUNC3_B  = 3'b000;
    localparam logic [2:0] FUNC3_H  = 3'b001;
    localparam logic [2:0] FUNC3_W  = 3'b010;
    localparam logic [2:0] FUNC3_BU = 3'b100;
    localparam logic [2:0] FUNC3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/load_ext.sv
// Load data extender.
// Sign- or zero-extends an LSB-aligned byte/half per funct3.
module load_ext
    import lsq_pkg::*;
(
    input  logic [2:0]        func3,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] data
);

    // Select extension from funct3; words pass through
    always_comb begin
        data = raw;
        unique case (func3)
            FUNC3_B:  data = {{24{raw[7]}}, raw[7:0]};
            FUNC3_H:  data = {{16{raw[15]}}, raw[15:0]};
            FUNC3_BU: data = {24'd0, raw[7:0]};
            FUNC3_HU: data = {16'd0, raw[15:0]};
            default:  data = raw;
        endcase
    end

endmodule

// File: rtl/lsq.sv
// Load/store queue: in-order memory access from the head,
// CDB wake-up, committed-store retention across rollback.
module lsq
    import lsq_pkg::*;
#(
    parameter int               DEPTH   = 16,
    parameter int               ROB_W   = 4,
    parameter int               NUM_CDB = 2,
    parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       rollback,
    input  logic                       in_valid,
    input  logic                       in_is_store,
    input  logic [2:0]                 in_func3,
    input  logic                       in_rs1_rdy,
    input  logic                       in_rs2_rdy,
    input  logic [DATA_W-1:0]          in_rs1_val,
    input  logic [DATA_W-1:0]          in_rs2_val,
    input  logic [ROB_W-1:0]           in_rs1_tag,
    input  logic [ROB_W-1:0]           in_rs2_tag,
    input  logic [DATA_W-1:0]          in_imm,
    input  logic [ROB_W-1:0]           in_rob_id,
    output logic                       full,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]   cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0]  cdb_data,
    input  logic                       commit_valid,
    input  logic [ROB_W-1:0]           commit_rob_id,
    input  logic [ROB_W-1:0]           rob_head_id,
    output logic                       mem_req_valid,
    output logic                       mem_req_wr,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [2:0]                 mem_req_len,
    output logic [DATA_W-1:0]          mem_req_wdata,
    input  logic                       mem_resp_valid,
    input  logic [DATA_W-1:0]          mem_resp_rdata,
    output logic                       res_valid,
    output logic [ROB_W-1:0]           res_rob_id,
    output logic [DATA_W-1:0]          res_data
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    typedef struct packed {
        logic              valid;
        logic              is_store;
        logic [2:0]        func3;
        logic              rs1_rdy;
        logic [DATA_W-1:0] rs1_val;
        logic [ROB_W-1:0]  rs1_tag;
        logic              rs2_rdy;
        logic [DATA_W-1:0] rs2_val;
        logic [ROB_W-1:0]  rs2_tag;
        logic [DATA_W-1:0] imm;
        logic [ROB_W-1:0]  rob_id;
        logic              committed;
    } ent_t;

    ent_t          q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [PW:0]   ncommit;
    state_t        state;

    logic [ROB_W-1:0]  cdb_tag [NUM_CDB];
    logic [DATA_W-1:0] cdb_val [NUM_CDB];
    logic [DATA_W:0]   w1 [DEPTH];
    logic [DATA_W:0]   w2 [DEPTH];
    logic [DATA_W:0]   b1;
    logic [DATA_W:0]   b2;
    ent_t              new_ent;

    logic [ADDR_W-1:0] h_addr;
    logic [2:0]        h_len;
    logic              h_mem_ok;
    logic              can_issue;
    logic              retire;
    logic              ret_store;
    logic              drain_ld;
    logic              commit_hit;
    logic [PW-1:0]     head_ret;
    logic [PW-1:0]     head_flush;
    logic [PW:0]       ncommit_ret;
    logic [DATA_W-1:0] ext_data;

    // Unpack the flattened broadcast buses per channel
    always_comb begin
        for (int k = 0; k < NUM_CDB; k++) begin
            cdb_tag[k] = cdb_rob_id[k*ROB_W +: ROB_W];
            cdb_val[k] = cdb_data[k*DATA_W +: DATA_W];
        end
    end

    // {hit, data}; scanning downward lets the lowest channel win
    function automatic logic [DATA_W:0] cdb_match(
        input logic [ROB_W-1:0] tag
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_tag[k] == tag) begin
                r = {1'b1, cdb_val[k]};
            end
        end
        return r;
    endfunction

    // Per-entry wake-up lookups
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w1[i] = cdb_match(q[i].rs1_tag);
            w2[i] = cdb_match(q[i].rs2_tag);
        end
    end

    assign b1 = cdb_match(in_rs1_tag);
    assign b2 = cdb_match(in_rs2_tag);

    // New entry with same-cycle broadcast bypass
    always_comb begin
        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.is_store  = in_is_store;
        new_ent.func3     = in_func3;
        new_ent.rs1_rdy   = in_rs1_rdy || b1[DATA_W];
        new_ent.rs1_val   = (!in_rs1_rdy && b1[DATA_W])
                          ? b1[DATA_W-1:0] : in_rs1_val;
        new_ent.rs1_tag   = in_rs1_tag;
        new_ent.rs2_rdy   = in_rs2_rdy || b2[DATA_W];
        new_ent.rs2_val   = (!in_rs2_rdy && b2[DATA_W])
                          ? b2[DATA_W-1:0] : in_rs2_val;
        new_ent.rs2_tag   = in_rs2_tag;
        new_ent.imm       = in_imm;
        new_ent.rob_id    = in_rob_id;
        new_ent.committed = 1'b0;
    end

    // Head request fields and byte count
    assign h_addr = q[head].rs1_val + q[head].imm;

    always_comb begin
        unique case (q[head].func3[1:0])
            2'b00:   h_len = 3'd1;
            2'b01:   h_len = 3'd2;
            default: h_len = 3'd4;
        endcase
    end

    // I/O loads wait until they are the oldest ROB entry
    assign h_mem_ok = q[head].is_store ? q[head].committed
                    : (!rollback && (h_addr < IO_BASE
                       || q[head].rob_id == rob_head_id));

    assign can_issue = (count != '0) && q[head].rs1_rdy
                     && q[head].rs2_rdy && h_mem_ok;

    assign retire    = (state == ST_WAIT) && mem_resp_valid;
    assign ret_store = retire && q[head].is_store;
    assign drain_ld  = (state == ST_WAIT) && !mem_resp_valid
                     && !q[head].is_store;

    assign head_ret    = head + PW'(retire);
    assign head_flush  = head_ret + PW'(drain_ld);
    assign ncommit_ret = ncommit - (PW+1)'(ret_store);

    // Store commit lookup
    always_comb begin
        commit_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid && q[i].valid && q[i].is_store
                && !q[i].committed && q[i].rob_id == commit_rob_id) begin
                commit_hit = 1'b1;
            end
        end
    end

    assign full = (count == FULL_CNT);

    load_ext u_ext (
        .func3 (q[head].func3),
        .raw   (mem_resp_rdata),
        .data  (ext_data)
    );

    // Queue storage, pointers and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ncommit <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else if (rdy) begin
            if (rollback) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!q[i].committed) begin
                        q[i].valid <= 1'b0;
                    end
                end
                if (retire) begin
                    q[head].valid <= 1'b0;
                end
                head    <= head_flush;
                tail    <= head_flush + ncommit_ret[PW-1:0];
                count   <= ncommit_ret;
                ncommit <= ncommit_ret;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q[i].valid && !q[i].rs1_rdy && w1[i][DATA_W]) begin
                        q[i].rs1_rdy <= 1'b1;
                        q[i].rs1_val <= w1[i][DATA_W-1:0];
                    end
                    if (q[i].valid && !q[i].rs2_rdy && w2[i][DATA_W]) begin
                        q[i].rs2_rdy <= 1'b1;
                        q[i].rs2_val <= w2[i][DATA_W-1:0];
                    end
                    if (commit_valid && q[i].valid && q[i].is_store
                        && !q[i].committed
                        && q[i].rob_id == commit_rob_id) begin
                        q[i].committed <= 1'b1;
                    end
                end
                if (in_valid) begin
                    q[tail] <= new_ent;
                end
                if (retire) begin
                    q[head].valid <= 1'b0;
                end
                head    <= head_ret;
                tail    <= tail + PW'(in_valid);
                count   <= count - (PW+1)'(retire) + (PW+1)'(in_valid);
                ncommit <= ncommit_ret + (PW+1)'(commit_hit);
            end
        end
    end

    // Memory FSM with registered request and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            mem_req_valid <= 1'b0;
            mem_req_wr    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_len   <= '0;
            mem_req_wdata <= '0;
            res_valid     <= 1'b0;
            res_rob_id    <= '0;
            res_data      <= '0;
        end else if (rdy) begin
            res_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (can_issue) begin
                        mem_req_valid <= 1'b1;
                        mem_req_wr    <= q[head].is_store;
                        mem_req_addr  <= h_addr;
                        mem_req_len   <= h_len;
                        mem_req_wdata <= q[head].rs2_val;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_IDLE;
                        if (!q[head].is_store) begin
                            res_valid  <= 1'b1;
                            res_rob_id <= q[head].rob_id;
                            res_data   <= ext_data;
                        end
                    end else if (rollback && !q[head].is_store) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mem_resp_valid) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
